reg_pla: RTL and testbench

Registered, field-programmable PLA that succeeds the fixed three-input, one-output PAL/PLA experiment. It has parametrised input, product-term and output counts. The AND and OR planes are loaded serially through a valid/ready handshake into a shadow store and committed atomically. Outputs are registered, so the block acts as a small programmable state/decode element between the input pins and downstream logic.

---
 rtl/pla_pkg.sv | 41 ++++
 rtl/pla_plane.sv | 47 ++++
 rtl/reg_pla.sv | 130 +++++++++++++
 tb/tb_reg_pla.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pla_pkg
// Description : Shared defaults, configuration-size helpers and FSM state
//               encoding for the registered field-programmable PLA.
//               Optional feature macro: PLA_POLARITY_EN (adds one output
//               polarity bit per output at the tail of the config stream).
// Revision    : 1.0 - initial release
// ============================================================================
package pla_pkg;

   localparam int DEF_N_IN   = 3;
   localparam int DEF_N_TERM = 8;
   localparam int DEF_N_OUT  = 1;

`ifdef PLA_POLARITY_EN
   localparam int POL_EN = 1;
`else
   localparam int POL_EN = 0;
`endif

   function automatic int and_bits(input int n_in, input int n_term);
      return 2 * n_in * n_term;
   endfunction

   function automatic int or_bits(input int n_term, input int n_out);
      return n_out * n_term;
   endfunction

   function automatic int cfg_bits(input int n_in, input int n_term, input int n_out);
      return and_bits(n_in, n_term) + or_bits(n_term, n_out) + POL_EN * n_out;
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pla_plane.sv
`default_nettype none
// ============================================================================
// Module      : pla_plane
// Description : Combinational AND/OR plane evaluation. Produces the
//               unregistered OR-plane result from the active plane vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module pla_plane
   import pla_pkg::*;
#(
   parameter int N_IN   = DEF_N_IN,
   parameter int N_TERM = DEF_N_TERM,
   parameter int N_OUT  = DEF_N_OUT
)(
   input  logic [2*N_IN*N_TERM-1:0] and_plane,
   input  logic [N_OUT*N_TERM-1:0]  or_plane,
   input  logic [N_IN-1:0]          in,
   output logic [N_OUT-1:0]         or_out
);

   logic [N_TERM-1:0] w_term;

   for (genvar t = 0; t < N_TERM; t++) begin : g_term
      logic [2*N_IN-1:0] w_row;
      logic              w_hit;

      assign w_row = and_plane[t*2*N_IN +: 2*N_IN];

      // A term fires only when at least one literal is enabled and none is violated;
      // enabling both x and ~x therefore can never fire.
      always_comb begin
         w_hit = |w_row;
         for (int i = 0; i < N_IN; i++) begin
            if (w_row[2*i]   && !in[i]) w_hit = 1'b0;
            if (w_row[2*i+1] &&  in[i]) w_hit = 1'b0;
         end
      end

      assign w_term[t] = w_hit;
   end

   for (genvar o = 0; o < N_OUT; o++) begin : g_out
      assign or_out[o] = |(or_plane[o*N_TERM +: N_TERM] & w_term);
   end

endmodule
`default_nettype wire

// File: rtl/reg_pla.sv
`default_nettype none
// ============================================================================
// Module      : reg_pla
// Description : Registered field-programmable PLA. AND/OR planes (and the
//               optional polarity bits) are shifted serially into a shadow
//               store through a valid/ready handshake and committed to the
//               active planes atomically on the final bit.
//               Optional feature macro: PLA_POLARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_pla
   import pla_pkg::*;
#(
   parameter int N_IN   = DEF_N_IN,
   parameter int N_TERM = DEF_N_TERM,
   parameter int N_OUT  = DEF_N_OUT
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_IN-1:0]   in,
   output logic [N_OUT-1:0]  out,
   input  logic              cfg_start,
   input  logic              cfg_valid,
   input  logic              cfg_bit,
   output logic              cfg_ready,
   output logic              cfg_done,
   output logic              cfg_ok
);

   localparam int c_and_bits = and_bits(N_IN, N_TERM);
   localparam int c_or_bits  = or_bits(N_TERM, N_OUT);
   localparam int c_cfg_bits = cfg_bits(N_IN, N_TERM, N_OUT);
   localparam int c_cnt_w    = $clog2(c_cfg_bits + 1);
   localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(c_cfg_bits - 1);

   state_t                  r_state;
   state_t                  w_state_next;
   logic [c_cnt_w-1:0]      r_cnt;
   logic [c_cfg_bits-1:0]   r_shadow;
   logic [c_cfg_bits-1:0]   w_shadow_next;
   logic [c_cfg_bits-1:0]   r_active;
   logic                    r_ok;
   logic                    r_done;
   logic [N_OUT-1:0]        r_out;
   logic                    w_accept;
   logic                    w_last;
   logic [N_OUT-1:0]        w_eval;
   logic [N_OUT-1:0]        w_pol;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Next state and handshake; a restart pulse in LOAD blocks acceptance that cycle.
   always_comb begin
      w_state_next = r_state;
      cfg_ready    = 1'b0;
      case (r_state)
         IDLE, RUN: begin
            if (cfg_start) w_state_next = LOAD;
         end
         LOAD: begin
            cfg_ready = !cfg_start;
            if (w_last) w_state_next = RUN;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_accept = cfg_ready && cfg_valid;
   assign w_last   = w_accept && (r_cnt == c_last_idx);

   // Shadow image including the bit being accepted, so the commit sees the final bit.
   always_comb begin
      w_shadow_next = r_shadow;
      if (w_accept) w_shadow_next[r_cnt] = cfg_bit;
   end

   // Bit counter, shadow store and atomic commit into the active planes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_shadow <= '0;
         r_active <= '0;
         r_ok     <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done   <= w_last;
         r_shadow <= w_shadow_next;
         if (cfg_start || w_last) r_cnt <= '0;
         else if (w_accept)       r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_active <= w_shadow_next;
            r_ok     <= 1'b1;
         end
      end
   end

   pla_plane #(
      .N_IN   (N_IN),
      .N_TERM (N_TERM),
      .N_OUT  (N_OUT)
   ) u_plane (
      .and_plane (r_active[c_and_bits-1:0]),
      .or_plane  (r_active[c_and_bits +: c_or_bits]),
      .in        (in),
      .or_out    (w_eval)
   );

`ifdef PLA_POLARITY_EN
   assign w_pol = r_active[c_and_bits + c_or_bits +: N_OUT];
`else
   assign w_pol = '0;
`endif

   // Registered outputs; forced low until a configuration has been committed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_out <= '0;
      else if (r_ok) r_out <= w_eval ^ w_pol;
      else           r_out <= '0;
   end

   assign out      = r_out;
   assign cfg_done = r_done;
   assign cfg_ok   = r_ok;

endmodule
`default_nettype wire

// File: tb/tb_reg_pla.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_pla
// Description : Self-checking bench for reg_pla with randomized inputs and a
//               behavioural PLA model. Honours PLA_POLARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_pla;

`ifdef PLA_POLARITY_EN
   localparam int POL = 1;
`else
   localparam int POL = 0;
`endif
   localparam int AND_BITS = 48;
   localparam int OR_BITS  = 8;
   localparam int CFG_BITS = AND_BITS + OR_BITS + POL;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] in;
   logic [0:0] out;
   logic       cfg_start, cfg_valid, cfg_bit;
   logic       cfg_ready, cfg_done, cfg_ok;

   int errors = 0;
   int checks = 0;

   // bench-side view of the block
   logic        tb_loading;
   int          tb_idx;
   logic [63:0] tb_shadow;
   logic [63:0] tb_active;
   logic        tb_ok;
   logic        tb_commit;
   logic        prev_out;
   int          done_seen;

   reg_pla u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in),
      .out       (out),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_bit   (cfg_bit),
      .cfg_ready (cfg_ready),
      .cfg_done  (cfg_done),
      .cfg_ok    (cfg_ok)
   );

   always #5 clk = ~clk;

   // PLA meaning of a configuration image, straight from the plane definitions.
   function automatic logic eval_model(input logic [63:0] c, input logic okv, input logic [2:0] x);
      logic acc;
      logic val;
      int   lits;
      if (!okv) return 1'b0;
      acc = 1'b0;
      for (int t = 0; t < 8; t++) begin
         if (c[AND_BITS + t]) begin
            lits = 0;
            val  = 1'b1;
            for (int i = 0; i < 3; i++) begin
               if (c[t*6 + 2*i])     begin lits++; if (!x[i]) val = 1'b0; end
               if (c[t*6 + 2*i + 1]) begin lits++; if (x[i])  val = 1'b0; end
            end
            if (lits > 0 && val) acc = 1'b1;
         end
      end
      if (POL == 1) acc = acc ^ c[AND_BITS + OR_BITS];
      return acc;
   endfunction

   function automatic logic [63:0] set_term(input logic [63:0] c, input int t,
                                            input logic [2:0] pos, input logic [2:0] neg);
      logic [63:0] r;
      r = c;
      for (int i = 0; i < 3; i++) begin
         r[t*6 + 2*i]     = pos[i];
         r[t*6 + 2*i + 1] = neg[i];
      end
      return r;
   endfunction

   function automatic logic [63:0] majority_cfg();
      logic [63:0] c;
      c = '0;
      c = set_term(c, 0, 3'b011, 3'b000);
      c = set_term(c, 1, 3'b101, 3'b000);
      c = set_term(c, 2, 3'b110, 3'b000);
      c[AND_BITS + 0] = 1'b1;
      c[AND_BITS + 1] = 1'b1;
      c[AND_BITS + 2] = 1'b1;
      if (POL == 1) c[AND_BITS + OR_BITS] = 1'b1;
      return c;
   endfunction

   // One clock: drive at the falling edge, check handshake, output and status after the rising edge.
   task automatic tick(input logic st, input logic v, input logic b, input logic [2:0] x);
      logic exp_ready, acc, last, exp_out;
      in = x; cfg_start = st; cfg_valid = v; cfg_bit = b;
      #1;
      checks++;
      if (out !== prev_out) begin
         errors++; $display("FAIL comb_path: out=%b required=%b", out, prev_out);
      end
      exp_ready = tb_loading && !st;
      checks++;
      if (cfg_ready !== exp_ready) begin
         errors++; $display("FAIL cfg_ready: got=%b required=%b idx=%0d", cfg_ready, exp_ready, tb_idx);
      end
      acc     = exp_ready && v;
      last    = acc && (tb_idx == CFG_BITS - 1);
      exp_out = eval_model(tb_active, tb_ok, x);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out !== exp_out) begin
         errors++; $display("FAIL out: in=%b got=%b required=%b", x, out, exp_out);
      end
      checks++;
      if (cfg_done !== last) begin
         errors++; $display("FAIL cfg_done: got=%b required=%b idx=%0d", cfg_done, last, tb_idx);
      end
      if (cfg_done === 1'b1) done_seen++;
      if (st) begin
         tb_loading = 1'b1; tb_idx = 0;
      end else if (acc) begin
         tb_shadow[tb_idx] = b;
         if (last) begin
            tb_active = tb_shadow; tb_ok = 1'b1; tb_loading = 1'b0; tb_idx = 0; tb_commit = 1'b1;
         end else begin
            tb_idx++;
         end
      end
      checks++;
      if (cfg_ok !== tb_ok) begin
         errors++; $display("FAIL cfg_ok: got=%b required=%b", cfg_ok, tb_ok);
      end
      prev_out  = exp_out;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
   endtask

   // Full load: start pulse, then beats until commit (optional gaps, optional restart at a beat index).
   task automatic run_stream(input logic [63:0] nc, input int restart_at, input bit gaps);
      int  cyc;
      bit  restarted;
      logic st, v;
      tb_commit = 1'b0;
      done_seen = 0;
      restarted = 0;
      tick(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom));
      cyc = 0;
      while (!tb_commit && cyc < 400) begin
         st = 1'b0;
         if (restart_at >= 0 && !restarted && tb_idx == restart_at) begin
            st = 1'b1; restarted = 1;
         end
         v = gaps ? 1'(cyc % 2) : 1'b1;
         if (st) v = 1'b1;
         tick(st, v, nc[tb_idx], 3'($urandom));
         cyc++;
      end
      if (!tb_commit) begin
         errors++; $display("FAIL load_timeout: beats=%0d required=%0d", tb_idx, CFG_BITS);
      end else if (restart_at < 0) begin
         checks++;
         if (cyc != (gaps ? 2*CFG_BITS : CFG_BITS)) begin
            errors++; $display("FAIL load_cycles: got=%0d required=%0d", cyc, gaps ? 2*CFG_BITS : CFG_BITS);
         end
      end
      tick(1'b0, 1'b0, 1'b0, 3'($urandom));
      checks++;
      if (done_seen != 1) begin
         errors++; $display("FAIL done_count: got=%0d required=1", done_seen);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (out !== 1'b0)       begin errors++; $display("FAIL rst_out: got=%b required=0", out); end
      checks++; if (cfg_ok !== 1'b0)    begin errors++; $display("FAIL rst_ok: got=%b required=0", cfg_ok); end
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got=%b required=0", cfg_ready); end
      checks++; if (cfg_done !== 1'b0)  begin errors++; $display("FAIL rst_done: got=%b required=0", cfg_done); end
      tb_loading = 1'b0; tb_idx = 0; tb_shadow = '0; tb_active = '0; tb_ok = 1'b0; prev_out = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      // valid bits without a start pulse must be ignored
      for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, 1'($urandom_range(1)), 3'($urandom));
   endtask

   task automatic test_majority();
      run_stream(majority_cfg(), -1, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 3'b011);
      checks++;
      if (out !== 1'(POL == 1 ? 0 : 1)) begin
         errors++; $display("FAIL maj_011: got=%b required=%0d", out, POL == 1 ? 0 : 1);
      end
      tick(1'b0, 1'b0, 1'b0, 3'b001);
      checks++;
      if (out !== 1'(POL == 1 ? 1 : 0)) begin
         errors++; $display("FAIL maj_001: got=%b required=%0d", out, POL == 1 ? 1 : 0);
      end
      tick(1'b0, 1'b0, 1'b0, 3'b000);
      checks++;
      if (out !== 1'(POL)) begin
         errors++; $display("FAIL maj_000: got=%b required=%0d", out, POL);
      end
      for (int k = 0; k < 16; k++) tick(1'b0, 1'($urandom_range(1)), 1'b0, 3'($urandom));
   endtask

   task automatic test_reset_midload();
      tick(1'b1, 1'b0, 1'b0, 3'($urandom));
      for (int k = 0; k < 20; k++) tick(1'b0, 1'b1, 1'($urandom_range(1)), 3'($urandom));
      do_reset();
      for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, 1'($urandom_range(1)), 3'($urandom));
   endtask

   task automatic test_backpressure();
      run_stream(majority_cfg(), -1, 1'b1);
      for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b0, 3'($urandom));
   endtask

   task automatic test_restart();
      logic [63:0] c;
      c = set_term('0, 0, 3'b001, 3'b010);
      c[AND_BITS] = 1'b1;
      run_stream(c, 20, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 3'b001);
      checks++;
      if (out !== 1'b1) begin
         errors++; $display("FAIL restart_001: got=%b required=1", out);
      end
      for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b0, 3'($urandom));
   endtask

   task automatic test_contradictory();
      logic [63:0] c;
      c = set_term('0, 0, 3'b001, 3'b001);
      c[AND_BITS +: 8] = 8'hFF;
      run_stream(c, -1, 1'b0);
      for (int x = 0; x < 8; x++) begin
         tick(1'b0, 1'b0, 1'b0, 3'(x));
         checks++;
         if (out !== 1'b0) begin
            errors++; $display("FAIL contra: in=%0d got=%b required=0", x, out);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; in = '0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
      tb_loading = 1'b0; tb_idx = 0; tb_shadow = '0; tb_active = '0; tb_ok = 1'b0;
      tb_commit = 1'b0; prev_out = 1'b0; done_seen = 0;
      test_reset();
      test_majority();
      test_reset_midload();
      test_backpressure();
      test_restart();
      test_contradictory();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
